// File: rtl/raisin64_sched_pkg.sv
// Shared definitions for the issue scheduler.
// Holds the unit-field encodings, the instruction class enum, and the helper
// that turns (type, unit) into a class.
package raisin64_sched_pkg;

  localparam logic [2:0] UNIT_ADVINT    = 3'h4;
  localparam logic [2:0] UNIT_MEM_STORE = 3'h6;
  localparam logic [2:0] UNIT_BRANCH    = 3'h7;

  typedef enum logic [2:0] {
    ALU,
    ADVINT,
    MEM,
    BRANCH,
    ILLEGAL
  } sched_class_t;

  // unit[2]==0 is always ALU; unit 7 is always BRANCH; the remaining
  // units 4..6 are MEM for type 1, while type 0 only defines unit 4 (ADVINT).
  function automatic sched_class_t decode_class(input logic ty,
                                                input logic [2:0] unit_f);
    if (!unit_f[2])                 return ALU;
    if (unit_f == UNIT_BRANCH)      return BRANCH;
    if (ty)                         return MEM;
    if (unit_f == UNIT_ADVINT)      return ADVINT;
    return ILLEGAL;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first requester at or after a pointer.
// Ports:
//   req        N-bit request vector (one bit per candidate)
//   ptr        index at which the search starts (must be < N)
//   grant      one-hot grant, all zero when nothing requests
//   grant_idx  index of the granted bit (0 when nothing requests)
module rr_arbiter #(
  parameter  int unsigned N     = 2,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic        found;
  int unsigned idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (k + 32'(ptr)) % N;
      if (!found && req[idx]) begin
        found            = 1'b1;
        grant[idx]       = 1'b1;
        grant_idx        = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// In-order single-instruction-per-cycle issue stage between decode and the
// execution units. Tracks in-flight destinations in a per-register scoreboard,
// stalls on RAW/WAW hazards (with same-cycle writeback bypass), and raises a
// one-cycle enable to the chosen unit the cycle after acceptance.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   in_valid/in_type/in_unit         decoded instruction and its unit field
//   in_r1_rn/in_r2_rn                source registers
//   in_rd_rn/in_rd2_rn               destination registers
//   sc_ready                         instruction accepted this cycle (comb)
//   illegal                          pulse: illegal encoding accepted/dropped
//   wb_valid/wb_rn                   writeback strobes and register numbers
//   flush                            blocks acceptance this cycle
//   rd_out_rn/rd2_out_rn             destinations of last issued instruction
//   alu_en/alu_busy                  ALU pool issue pulses / busy flags
//   advint_en/memunit_en/branch_en   single-unit issue pulses
//   advint_busy/memunit_busy/branch_busy  single-unit busy flags
module issue_scheduler
  import raisin64_sched_pkg::*;
#(
  parameter int unsigned REG_W          = 6,
  parameter int unsigned NUM_ALU        = 2,
  parameter int unsigned NUM_WB         = 2,
  parameter int unsigned STARTUP_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_type,
  input  logic [2:0]              in_unit,
  input  logic [REG_W-1:0]        in_r1_rn,
  input  logic [REG_W-1:0]        in_r2_rn,
  input  logic [REG_W-1:0]        in_rd_rn,
  input  logic [REG_W-1:0]        in_rd2_rn,
  output logic                    sc_ready,
  output logic                    illegal,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [NUM_WB*REG_W-1:0] wb_rn,
  input  logic                    flush,
  output logic [REG_W-1:0]        rd_out_rn,
  output logic [REG_W-1:0]        rd2_out_rn,
  output logic [NUM_ALU-1:0]      alu_en,
  input  logic [NUM_ALU-1:0]      alu_busy,
  output logic                    advint_en,
  output logic                    memunit_en,
  output logic                    branch_en,
  input  logic                    advint_busy,
  input  logic                    memunit_busy,
  input  logic                    branch_busy
);

  localparam int unsigned NREGS         = 2 ** REG_W;
  localparam int unsigned RR_W          = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1;
  localparam logic [7:0]  STARTUP_LIMIT = 8'(STARTUP_CYCLES);

  sched_class_t       cls;
  logic               is_store;
  logic               set_rd;
  logic               set_rd2;
  logic [NREGS-1:0]   sb;
  logic [NREGS-1:0]   sb_next;
  logic [NREGS-1:0]   wb_hit;
  logic [NREGS-1:0]   hazard;
  logic               raw;
  logic               waw;
  logic               startup_done;
  logic               stall;
  logic               avail;
  logic [7:0]         startup_cnt;
  logic [RR_W-1:0]    rr;
  logic [NUM_ALU-1:0] alu_free;
  logic [NUM_ALU-1:0] alu_grant;
  logic [RR_W-1:0]    alu_idx;

  assign cls      = decode_class(in_type, in_unit);
  assign is_store = (cls == MEM) && (in_unit == UNIT_MEM_STORE);
  assign set_rd   = (cls == ALU) || (cls == ADVINT) || ((cls == MEM) && !is_store);
  assign set_rd2  = (cls == ADVINT);

  // Registers being written back this cycle; duplicates across ports collapse.
  always_comb begin
    wb_hit = '0;
    for (int unsigned i = 0; i < NUM_WB; i++) begin
      if (wb_valid[i]) wb_hit[wb_rn[i*REG_W +: REG_W]] = 1'b1;
    end
  end

  // Writeback in the current cycle bypasses the scoreboard.
  assign hazard = sb & ~wb_hit;

  assign raw = hazard[in_r1_rn] | hazard[in_r2_rn];
  assign waw = (set_rd & hazard[in_rd_rn]) | (set_rd2 & hazard[in_rd2_rn]);

  assign startup_done = (startup_cnt == STARTUP_LIMIT);
  assign stall        = !startup_done || flush || branch_busy || raw || waw;

  assign alu_free = ~alu_busy;

  rr_arbiter #(.N(NUM_ALU)) u_alu_arb (
    .req       (alu_free),
    .ptr       (rr),
    .grant     (alu_grant),
    .grant_idx (alu_idx)
  );

  always_comb begin
    avail = 1'b1;
    case (cls)
      ALU:     avail = |alu_free;
      ADVINT:  avail = !advint_busy;
      MEM:     avail = !memunit_busy;
      BRANCH:  avail = 1'b1;
      ILLEGAL: avail = 1'b1;
      default: avail = 1'b0;
    endcase
  end

  assign sc_ready = in_valid && !stall && avail;

  // Clears first, then sets, so a set wins over a same-cycle clear.
  always_comb begin
    sb_next = sb & ~wb_hit;
    if (sc_ready) begin
      if (set_rd)  sb_next[in_rd_rn]  = 1'b1;
      if (set_rd2) sb_next[in_rd2_rn] = 1'b1;
    end
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      startup_cnt <= '0;
      sb          <= '0;
      rr          <= '0;
      alu_en      <= '0;
      advint_en   <= 1'b0;
      memunit_en  <= 1'b0;
      branch_en   <= 1'b0;
      illegal     <= 1'b0;
      rd_out_rn   <= '0;
      rd2_out_rn  <= '0;
    end else begin
      if (!startup_done) startup_cnt <= startup_cnt + 8'd1;
      sb         <= sb_next;
      alu_en     <= (sc_ready && cls == ALU) ? alu_grant : '0;
      advint_en  <= sc_ready && (cls == ADVINT);
      memunit_en <= sc_ready && (cls == MEM);
      branch_en  <= sc_ready && (cls == BRANCH);
      illegal    <= sc_ready && (cls == ILLEGAL);
      if (sc_ready && cls == ALU) begin
        rr <= (alu_idx == RR_W'(NUM_ALU - 1)) ? '0 : alu_idx + RR_W'(1);
      end
      // A dropped illegal instruction issues nothing, so it leaves the
      // last-issued destination untouched.
      if (sc_ready && cls != ILLEGAL) rd_out_rn  <= in_rd_rn;
      if (sc_ready && cls == ADVINT)  rd2_out_rn <= in_rd2_rn;
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
module tb_issue_scheduler;

  localparam int RW = 4;
  localparam int NA = 2;
  localparam int NW = 2;
  localparam int SU = 3;
  localparam int NR = 16;

  localparam int C_ALU = 0;
  localparam int C_ADV = 1;
  localparam int C_MEM = 2;
  localparam int C_BR  = 3;
  localparam int C_ILL = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid, in_type;
  logic [2:0]     in_unit;
  logic [RW-1:0]  in_r1_rn, in_r2_rn, in_rd_rn, in_rd2_rn;
  logic           sc_ready, illegal;
  logic [NW-1:0]  wb_valid;
  logic [NW*RW-1:0] wb_rn;
  logic           flush;
  logic [RW-1:0]  rd_out_rn, rd2_out_rn;
  logic [NA-1:0]  alu_en, alu_busy;
  logic           advint_en, memunit_en, branch_en;
  logic           advint_busy, memunit_busy, branch_busy;

  issue_scheduler #(
    .REG_W(RW), .NUM_ALU(NA), .NUM_WB(NW), .STARTUP_CYCLES(SU)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_type(in_type), .in_unit(in_unit),
    .in_r1_rn(in_r1_rn), .in_r2_rn(in_r2_rn),
    .in_rd_rn(in_rd_rn), .in_rd2_rn(in_rd2_rn),
    .sc_ready(sc_ready), .illegal(illegal),
    .wb_valid(wb_valid), .wb_rn(wb_rn), .flush(flush),
    .rd_out_rn(rd_out_rn), .rd2_out_rn(rd2_out_rn),
    .alu_en(alu_en), .alu_busy(alu_busy),
    .advint_en(advint_en), .memunit_en(memunit_en), .branch_en(branch_en),
    .advint_busy(advint_busy), .memunit_busy(memunit_busy),
    .branch_busy(branch_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            stamp;
    logic [NA-1:0] alu;
    logic          adv, mem, br, ill;
    logic [RW-1:0] rd, rd2;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   gcyc  = 0;

  // Reference model state
  bit            msb[NR];
  int            mrr;
  int            mcyc;
  logic [RW-1:0] m_rd2;

  always @(posedge clk) gcyc <= gcyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, gcyc);
    end
  endtask

  function automatic int classify(input logic t, input logic [2:0] u);
    if (u == 3'd7) return C_BR;
    if (u < 3'd4)  return C_ALU;
    if (t)         return C_MEM;
    if (u == 3'd4) return C_ADV;
    return C_ILL;
  endfunction

  task automatic quiet_env();
    wb_valid = '0; wb_rn = '0; flush = 1'b0;
    alu_busy = '0; advint_busy = 1'b0; memunit_busy = 1'b0; branch_busy = 1'b0;
  endtask

  task automatic drive(input logic v, input logic t, input logic [2:0] u,
                       input int r1, input int r2, input int rd, input int rd2);
    in_valid = v; in_type = t; in_unit = u;
    in_r1_rn = RW'(r1); in_r2_rn = RW'(r2);
    in_rd_rn = RW'(rd); in_rd2_rn = RW'(rd2);
  endtask

  // Called at a negedge with inputs already driven; evaluates the model,
  // checks sc_ready, queues the expected pulse, advances to the next negedge.
  task automatic step();
    bit   wbh[NR];
    bit   haz[NR];
    int   cls, pick, idx;
    bit   st, setrd, setrd2, stall, avail, acc;
    exp_t e;
    #1;
    for (int r = 0; r < NR; r++) wbh[r] = 0;
    for (int i = 0; i < NW; i++)
      if (wb_valid[i]) wbh[int'(wb_rn[i*RW +: RW])] = 1;
    for (int r = 0; r < NR; r++) haz[r] = msb[r] && !wbh[r];
    cls    = classify(in_type, in_unit);
    st     = (cls == C_MEM) && (in_unit == 3'd6);
    setrd  = (cls == C_ALU) || (cls == C_ADV) || (cls == C_MEM && !st);
    setrd2 = (cls == C_ADV);
    stall  = (mcyc < SU) || flush || branch_busy
             || haz[int'(in_r1_rn)] || haz[int'(in_r2_rn)]
             || (setrd && haz[int'(in_rd_rn)]) || (setrd2 && haz[int'(in_rd2_rn)]);
    pick = -1;
    for (int k = 0; k < NA; k++) begin
      idx = (mrr + k) % NA;
      if (pick < 0 && !alu_busy[idx]) pick = idx;
    end
    case (cls)
      C_ALU:   avail = (pick >= 0);
      C_ADV:   avail = !advint_busy;
      C_MEM:   avail = !memunit_busy;
      default: avail = 1;
    endcase
    acc = in_valid && !stall && avail;
    chk("sc_ready", 32'(sc_ready), 32'(acc));
    if (acc) begin
      e.stamp = gcyc;
      e.alu   = '0;
      if (cls == C_ALU) e.alu[pick] = 1'b1;
      e.adv = (cls == C_ADV);
      e.mem = (cls == C_MEM);
      e.br  = (cls == C_BR);
      e.ill = (cls == C_ILL);
      e.rd  = in_rd_rn;
      if (cls == C_ADV) m_rd2 = in_rd2_rn;
      e.rd2 = m_rd2;
      q.push_back(e);
    end
    for (int r = 0; r < NR; r++) if (wbh[r]) msb[r] = 0;
    if (acc) begin
      if (setrd  && in_rd_rn  != 0) msb[int'(in_rd_rn)]  = 1;
      if (setrd2 && in_rd2_rn != 0) msb[int'(in_rd2_rn)] = 1;
      if (cls == C_ALU) mrr = (pick + 1) % NA;
    end
    if (mcyc < SU) mcyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 3'd0, 0, 0, 0, 0);
    quiet_env();
    #1;
    chk("reset_outputs",
        {alu_en, advint_en, memunit_en, branch_en, illegal, rd_out_rn, rd2_out_rn}, 32'd0);
    q.delete();
    for (int r = 0; r < NR; r++) msb[r] = 0;
    mrr = 0; mcyc = 0; m_rd2 = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_cycle();
    drive(($urandom_range(0, 9) < 8), 1'($urandom), 3'($urandom_range(0, 7)),
          $urandom_range(0, NR-1), $urandom_range(0, NR-1),
          $urandom_range(0, NR-1), $urandom_range(0, NR-1));
    for (int i = 0; i < NW; i++) begin
      wb_valid[i] = ($urandom_range(0, 9) < 4);
      wb_rn[i*RW +: RW] = RW'($urandom_range(0, NR-1));
    end
    flush        = ($urandom_range(0, 19) == 0);
    branch_busy  = ($urandom_range(0, 19) == 0);
    for (int i = 0; i < NA; i++) alu_busy[i] = ($urandom_range(0, 4) == 0);
    advint_busy  = ($urandom_range(0, 4) == 0);
    memunit_busy = ($urandom_range(0, 4) == 0);
    step();
  endtask

  // Monitor: pops one expectation per issue pulse seen on the outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n !== 1'b1) continue;
      while (q.size() > 0 && q[0].stamp < gcyc - 1) begin
        e = q.pop_front();
        tests++;
        fails++;
        $display("FAIL missing_pulse: got no issue pulse expected one from cycle %0d", e.stamp);
      end
      if (|alu_en || advint_en || memunit_en || branch_en || illegal) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_pulse: got alu=%b adv=%b mem=%b br=%b ill=%b expected none",
                   alu_en, advint_en, memunit_en, branch_en, illegal);
        end else begin
          e = q.pop_front();
          chk("issue_pulses", {alu_en, advint_en, memunit_en, branch_en, illegal},
              {e.alu, e.adv, e.mem, e.br, e.ill});
          if (!e.ill) chk("rd_out_rn", 32'(rd_out_rn), 32'(e.rd));
          chk("rd2_out_rn", 32'(rd2_out_rn), 32'(e.rd2));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    drive(0, 0, 3'd0, 0, 0, 0, 0);
    quiet_env();
    #2;
    do_reset();

    // Start-up stall, then round-robin over back-to-back independent ALU ops
    drive(1, 0, 3'd1, 1, 2, 0, 0);
    repeat (6) step();

    // RAW: r3 <- r1+r2, then r4 <- r3+r1 waits for writeback of r3
    drive(1, 0, 3'd0, 1, 2, 3, 0); step();
    drive(1, 0, 3'd0, 3, 1, 4, 0); step(); step();
    wb_valid = 2'b01; wb_rn = {4'd0, 4'd3}; step();
    quiet_env(); drive(0, 0, 3'd0, 0, 0, 0, 0); step();
    wb_valid = 2'b01; wb_rn = {4'd0, 4'd4}; step();
    quiet_env();

    // ADVINT rd=5 rd2=6, reader of r6 stalls until both write back together
    drive(1, 0, 3'd4, 0, 0, 5, 6); step();
    drive(1, 0, 3'd2, 6, 0, 9, 0); step();
    wb_valid = 2'b11; wb_rn = {4'd6, 4'd5}; step();
    quiet_env();
    drive(1, 0, 3'd3, 5, 6, 0, 0); step();

    // Store sets nothing, so a reader of r7 does not stall
    drive(1, 1, 3'd6, 0, 0, 7, 0); step();
    drive(1, 0, 3'd0, 7, 0, 10, 0); step();

    // Illegal encoding, then flush and branch_busy blocking acceptance
    drive(1, 0, 3'd5, 0, 0, 11, 0); step();
    drive(1, 0, 3'd1, 1, 2, 12, 0); flush = 1'b1; step();
    flush = 1'b0; branch_busy = 1'b1; step();
    quiet_env(); drive(0, 0, 3'd0, 0, 0, 0, 0); step();

    repeat (3000) rand_cycle();

    // Asynchronous reset in the middle of traffic
    do_reset();
    repeat (400) rand_cycle();

    drive(0, 0, 3'd0, 0, 0, 0, 0);
    quiet_env();
    step();
    step();
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
